// File: rtl/digital_clock_alarm.sv
// 24-hour digital clock with prescaler, 12/24-hour display, auto-repeat set
// buttons, a separate alarm register set and a ring/snooze alarm controller.
module digital_clock_alarm #(
    parameter int TICK_COUNT    = 100_000_000,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int RING_SECS     = 60,
    parameter int SNOOZE_MIN    = 5
) (
    input  logic       clk,
    input  logic       sw,
    input  logic       mode24,
    input  logic       set_alarm,
    input  logic       btnL,
    input  logic       btnR,
    input  logic       alarm_en,
    input  logic       snooze,
    input  logic       dismiss,
    output logic [3:0] h2,
    output logic [3:0] h1,
    output logic [3:0] m2,
    output logic [3:0] m1,
    output logic [3:0] s2,
    output logic [3:0] s1,
    output logic       pm,
    output logic       alarm_ring,
    output logic       tick
);

    localparam int PW       = (TICK_COUNT > 1) ? $clog2(TICK_COUNT) : 1;
    localparam int REP_MAX  = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW       = $clog2(REP_MAX + 1);
    localparam int RING_W   = $clog2(RING_SECS + 1);
    localparam int SNZ_LOAD = SNOOZE_MIN * 60;
    localparam int SNZ_W    = $clog2(SNZ_LOAD + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RINGING = 2'd1,
        SNOOZE  = 2'd2
    } state_t;

    logic [PW-1:0]        presc_q, presc_d;
    logic [5:0]           hour_q, hour_d, min_q, min_d, sec_q, sec_d;
    logic [5:0]           al_hour_q, al_hour_d, al_min_q, al_min_d;
    logic [3:0]           sync1_q, sync1_d, sync2_q, sync2_d, prev_q, prev_d;
    logic [3:0]           rise;
    logic [1:0][RW-1:0]   rep_cnt_q, rep_cnt_d;
    logic [1:0]           rep_on_q, rep_on_d;
    logic [1:0]           rep_evt;
    logic                 ev_l, ev_r, time_adj, alarm_hit;
    state_t               state_q, state_d;
    logic [RING_W-1:0]    ring_q, ring_d;
    logic [SNZ_W-1:0]     snz_q, snz_d;
    logic [5:0]           hour_sel, min_sel, sec_sel, hour_disp;
    logic [7:0]           bcd_h, bcd_m, bcd_s;

    // Two-digit BCD of a 0..59 binary value
    function automatic logic [7:0] to_bcd(input logic [5:0] v);
        return {4'(v / 6'd10), 4'(v % 6'd10)};
    endfunction

    // Prescaler: tick marks the last cycle of each second
    always_comb begin
        tick    = (presc_q == PW'(TICK_COUNT - 1));
        presc_d = tick ? '0 : presc_q + 1'b1;
    end

    // Button synchronisers, rising-edge detection and hour/minute auto-repeat
    always_comb begin
        sync1_d   = {dismiss, snooze, btnR, btnL};
        sync2_d   = sync1_q;
        prev_d    = sync2_q;
        rise      = sync2_q & ~prev_q;
        rep_evt   = '0;
        rep_cnt_d = rep_cnt_q;
        rep_on_d  = rep_on_q;
        for (int i = 0; i < 2; i++) begin
            if (!sync2_q[i]) begin
                rep_cnt_d[i] = '0;
                rep_on_d[i]  = 1'b0;
            end else if (rise[i]) begin
                rep_evt[i]   = 1'b1;
                rep_cnt_d[i] = RW'(1);
                rep_on_d[i]  = 1'b0;
            end else if (!rep_on_q[i] && rep_cnt_q[i] == RW'(REPEAT_DELAY)) begin
                rep_evt[i]   = 1'b1;
                rep_cnt_d[i] = RW'(1);
                rep_on_d[i]  = 1'b1;
            end else if (rep_on_q[i] && rep_cnt_q[i] == RW'(REPEAT_PERIOD)) begin
                rep_evt[i]   = 1'b1;
                rep_cnt_d[i] = RW'(1);
            end else begin
                rep_cnt_d[i] = rep_cnt_q[i] + 1'b1;
            end
        end
    end

    // Timekeeping and adjustment; a time adjust swallows a coincident second step
    always_comb begin
        ev_r      = rep_evt[1];
        ev_l      = rep_evt[0] & ~rep_evt[1];
        time_adj  = ~set_alarm & (ev_r | ev_l);
        hour_d    = hour_q;
        min_d     = min_q;
        sec_d     = sec_q;
        al_hour_d = al_hour_q;
        al_min_d  = al_min_q;
        if (time_adj) begin
            if (ev_r) begin
                min_d = (min_q == 6'd59) ? 6'd0 : min_q + 6'd1;
            end else begin
                hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
            end
        end else if (tick) begin
            if (sec_q == 6'd59) begin
                sec_d = 6'd0;
                if (min_q == 6'd59) begin
                    min_d  = 6'd0;
                    hour_d = (hour_q == 6'd23) ? 6'd0 : hour_q + 6'd1;
                end else begin
                    min_d = min_q + 6'd1;
                end
            end else begin
                sec_d = sec_q + 6'd1;
            end
        end
        if (set_alarm) begin
            if (ev_r) begin
                al_min_d = (al_min_q == 6'd59) ? 6'd0 : al_min_q + 6'd1;
            end else if (ev_l) begin
                al_hour_d = (al_hour_q == 6'd23) ? 6'd0 : al_hour_q + 6'd1;
            end
        end
        alarm_hit = tick & ~time_adj & (sec_d == 6'd0) &
                    (hour_d == al_hour_q) & (min_d == al_min_q);
    end

    // Alarm controller: ring timeout, snooze countdown, dismiss has priority
    always_comb begin
        state_d = state_q;
        ring_d  = ring_q;
        snz_d   = snz_q;
        case (state_q)
            IDLE: begin
                if (alarm_hit) begin
                    state_d = RINGING;
                    ring_d  = '0;
                end
            end
            RINGING: begin
                if (rise[3]) begin
                    state_d = IDLE;
                end else if (rise[2]) begin
                    state_d = SNOOZE;
                    snz_d   = SNZ_W'(SNZ_LOAD);
                end else if (tick) begin
                    if (ring_q == RING_W'(RING_SECS - 1)) begin
                        state_d = IDLE;
                    end else begin
                        ring_d = ring_q + 1'b1;
                    end
                end
            end
            SNOOZE: begin
                if (rise[3]) begin
                    state_d = IDLE;
                end else if (tick) begin
                    if (snz_q <= SNZ_W'(1)) begin
                        state_d = RINGING;
                        ring_d  = '0;
                        snz_d   = '0;
                    end else begin
                        snz_d = snz_q - 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (!alarm_en) begin
            state_d = IDLE;
        end
    end

    // Display selection, 12-hour conversion and BCD split
    always_comb begin
        hour_sel  = set_alarm ? al_hour_q : hour_q;
        min_sel   = set_alarm ? al_min_q : min_q;
        sec_sel   = set_alarm ? 6'd0 : sec_q;
        hour_disp = hour_sel;
        pm        = 1'b0;
        if (!mode24) begin
            if (hour_sel == 6'd0) begin
                hour_disp = 6'd12;
            end else if (hour_sel > 6'd12) begin
                hour_disp = hour_sel - 6'd12;
                pm        = 1'b1;
            end else if (hour_sel == 6'd12) begin
                pm = 1'b1;
            end
        end
        bcd_h      = to_bcd(hour_disp);
        bcd_m      = to_bcd(min_sel);
        bcd_s      = to_bcd(sec_sel);
        h2         = bcd_h[7:4];
        h1         = bcd_h[3:0];
        m2         = bcd_m[7:4];
        m1         = bcd_m[3:0];
        s2         = bcd_s[7:4];
        s1         = bcd_s[3:0];
        alarm_ring = (state_q == RINGING);
    end

    // Prescaler, time and alarm registers
    always_ff @(posedge clk) begin
        if (sw) begin
            presc_q   <= '0;
            hour_q    <= '0;
            min_q     <= '0;
            sec_q     <= '0;
            al_hour_q <= '0;
            al_min_q  <= '0;
        end else begin
            presc_q   <= presc_d;
            hour_q    <= hour_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            al_hour_q <= al_hour_d;
            al_min_q  <= al_min_d;
        end
    end

    // Button synchroniser and repeat registers
    always_ff @(posedge clk) begin
        if (sw) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            prev_q    <= '0;
            rep_cnt_q <= '0;
            rep_on_q  <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            prev_q    <= prev_d;
            rep_cnt_q <= rep_cnt_d;
            rep_on_q  <= rep_on_d;
        end
    end

    // Alarm state register with ring and snooze counters
    always_ff @(posedge clk) begin
        if (sw) begin
            state_q <= IDLE;
            ring_q  <= '0;
            snz_q   <= '0;
        end else begin
            state_q <= state_d;
            ring_q  <= ring_d;
            snz_q   <= snz_d;
        end
    end

endmodule

// File: tb/tb_digital_clock_alarm.sv
// Directed bench for digital_clock_alarm with a 4-cycle second.
module tb_digital_clock_alarm;

    logic        clk = 1'b0;
    logic        sw, mode24, set_alarm, btnL, btnR, alarm_en, snooze, dismiss;
    logic [3:0]  h2, h1, m2, m1, s2, s1;
    logic        pm, alarm_ring, tick;
    logic [23:0] disp;
    int          checks = 0;
    int          fails  = 0;
    int          cyc    = 0;

    assign disp = {h2, h1, m2, m1, s2, s1};

    digital_clock_alarm #(
        .TICK_COUNT(4), .REPEAT_DELAY(8), .REPEAT_PERIOD(3),
        .RING_SECS(3), .SNOOZE_MIN(1)
    ) dut (
        .clk(clk), .sw(sw), .mode24(mode24), .set_alarm(set_alarm),
        .btnL(btnL), .btnR(btnR), .alarm_en(alarm_en), .snooze(snooze),
        .dismiss(dismiss), .h2(h2), .h1(h1), .m2(m2), .m1(m1), .s2(s2),
        .s1(s1), .pm(pm), .alarm_ring(alarm_ring), .tick(tick)
    );

    // Free-running 10-unit clock
    always #5 clk = ~clk;

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic run_to(input int target);
        while (cyc < target) step(1);
    endtask

    task automatic do_reset(input logic m24);
        sw = 1'b1; mode24 = m24; set_alarm = 1'b0; btnL = 1'b0; btnR = 1'b0;
        alarm_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
        step(2);
        sw = 1'b0;
        cyc = 0;
    endtask

    task automatic press(input bit left, input int n);
        for (int i = 0; i < n; i++) begin
            if (left) btnL = 1'b1; else btnR = 1'b1;
            step(1);
            btnL = 1'b0; btnR = 1'b0;
            step(1);
        end
    endtask

    task automatic test_reset();
        do_reset(1'b1);
        checks++; if (disp !== 24'h000000) begin fails++; $display("[TB] FAIL reset_disp: got %h expected 000000", disp); end
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL reset_ring: got %b expected 0", alarm_ring); end
        checks++; if (tick !== 1'b0) begin fails++; $display("[TB] FAIL reset_tick: got %b expected 0", tick); end
        mode24 = 1'b0; #1;
        checks++; if (disp !== 24'h120000 || pm !== 1'b0) begin fails++; $display("[TB] FAIL reset_12h: got %h pm %b expected 120000 pm 0", disp, pm); end
        run_to(3);
        checks++; if (tick !== 1'b1) begin fails++; $display("[TB] FAIL tick_first: got %b expected 1", tick); end
        run_to(4);
        checks++; if (tick !== 1'b0 || disp !== 24'h120001) begin fails++; $display("[TB] FAIL tick_after: got tick %b disp %h expected 0 120001", tick, disp); end
    endtask

    task automatic test_rollover();
        do_reset(1'b0);
        press(1'b1, 23);
        press(1'b0, 59);
        run_to(236);
        checks++; if (disp !== 24'h115959 || pm !== 1'b1) begin fails++; $display("[TB] FAIL roll_pre12: got %h pm %b expected 115959 pm 1", disp, pm); end
        run_to(239);
        checks++; if (tick !== 1'b1) begin fails++; $display("[TB] FAIL roll_tick: got %b expected 1", tick); end
        mode24 = 1'b1; #1;
        checks++; if (disp !== 24'h235959) begin fails++; $display("[TB] FAIL roll_pre24: got %h expected 235959", disp); end
        mode24 = 1'b0;
        run_to(240);
        checks++; if (disp !== 24'h120000 || pm !== 1'b0) begin fails++; $display("[TB] FAIL roll_post12: got %h pm %b expected 120000 pm 0", disp, pm); end
        mode24 = 1'b1; #1;
        checks++; if (disp !== 24'h000000) begin fails++; $display("[TB] FAIL roll_post24: got %h expected 000000", disp); end
    endtask

    task automatic test_pm12();
        do_reset(1'b0);
        press(1'b1, 12);
        run_to(26);
        checks++; if (disp !== 24'h120006 || pm !== 1'b1) begin fails++; $display("[TB] FAIL noon: got %h pm %b expected 120006 pm 1", disp, pm); end
        press(1'b1, 1);
        run_to(30);
        checks++; if (disp !== 24'h010007 || pm !== 1'b1) begin fails++; $display("[TB] FAIL hour13_12h: got %h pm %b expected 010007 pm 1", disp, pm); end
        mode24 = 1'b1; #1;
        checks++; if (disp !== 24'h130007 || pm !== 1'b0) begin fails++; $display("[TB] FAIL hour13_24h: got %h pm %b expected 130007 pm 0", disp, pm); end
    endtask

    task automatic test_auto_repeat();
        do_reset(1'b1);
        press(1'b0, 58);
        run_to(118);
        checks++; if (disp !== 24'h005829) begin fails++; $display("[TB] FAIL rep_start: got %h expected 005829", disp); end
        btnR = 1'b1;
        run_to(121);
        checks++; if (disp[23:8] !== 16'h0059) begin fails++; $display("[TB] FAIL rep_ev1: got %h expected 0059", disp[23:8]); end
        run_to(128);
        checks++; if (disp[23:8] !== 16'h0059) begin fails++; $display("[TB] FAIL rep_delay: got %h expected 0059", disp[23:8]); end
        run_to(129);
        checks++; if (disp[23:8] !== 16'h0000) begin fails++; $display("[TB] FAIL rep_ev2: got %h expected 0000", disp[23:8]); end
        run_to(132);
        checks++; if (disp[23:8] !== 16'h0001) begin fails++; $display("[TB] FAIL rep_ev3: got %h expected 0001", disp[23:8]); end
        run_to(135);
        checks++; if (disp[23:8] !== 16'h0002) begin fails++; $display("[TB] FAIL rep_ev4: got %h expected 0002", disp[23:8]); end
        btnR = 1'b0;
        run_to(141);
        checks++; if (disp[23:8] !== 16'h0002) begin fails++; $display("[TB] FAIL rep_release: got %h expected 0002", disp[23:8]); end
    endtask

    task automatic test_back_to_back();
        do_reset(1'b1);
        press(1'b1, 10);
        press(1'b0, 10);
        run_to(42);
        checks++; if (disp !== 24'h101010) begin fails++; $display("[TB] FAIL both_start: got %h expected 101010", disp); end
        btnL = 1'b1; btnR = 1'b1;
        step(1);
        btnL = 1'b0; btnR = 1'b0;
        run_to(45);
        checks++; if (disp !== 24'h101111) begin fails++; $display("[TB] FAIL both_same_cycle: got %h expected 101111", disp); end
    endtask

    task automatic test_adjust_on_tick();
        do_reset(1'b1);
        press(1'b1, 10);
        press(1'b0, 10);
        run_to(121);
        checks++; if (disp !== 24'h101030) begin fails++; $display("[TB] FAIL adj_start: got %h expected 101030", disp); end
        btnR = 1'b1;
        step(1);
        btnR = 1'b0;
        run_to(123);
        checks++; if (tick !== 1'b1 || disp !== 24'h101030) begin fails++; $display("[TB] FAIL adj_tick_cycle: got tick %b disp %h expected 1 101030", tick, disp); end
        run_to(124);
        checks++; if (disp !== 24'h101130) begin fails++; $display("[TB] FAIL adj_dropped_sec: got %h expected 101130", disp); end
        run_to(128);
        checks++; if (disp !== 24'h101131) begin fails++; $display("[TB] FAIL adj_next_sec: got %h expected 101131", disp); end
    endtask

    task automatic test_alarm_ring();
        do_reset(1'b1);
        set_alarm = 1'b1;
        press(1'b1, 7);
        press(1'b0, 30);
        run_to(76);
        checks++; if (disp !== 24'h073000) begin fails++; $display("[TB] FAIL alarm_disp: got %h expected 073000", disp); end
        set_alarm = 1'b0;
        press(1'b1, 7);
        press(1'b0, 29);
        run_to(150);
        checks++; if (disp !== 24'h072937) begin fails++; $display("[TB] FAIL alarm_time_set: got %h expected 072937", disp); end
        alarm_en = 1'b1;
        run_to(239);
        checks++; if (alarm_ring !== 1'b0 || disp !== 24'h072959) begin fails++; $display("[TB] FAIL alarm_pre: got ring %b disp %h expected 0 072959", alarm_ring, disp); end
        run_to(240);
        checks++; if (alarm_ring !== 1'b1 || disp !== 24'h073000) begin fails++; $display("[TB] FAIL alarm_rise: got ring %b disp %h expected 1 073000", alarm_ring, disp); end
        run_to(251);
        checks++; if (alarm_ring !== 1'b1) begin fails++; $display("[TB] FAIL ring_hold: got %b expected 1", alarm_ring); end
        run_to(252);
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL ring_timeout: got %b expected 0", alarm_ring); end
    endtask

    task automatic test_snooze();
        do_reset(1'b1);
        set_alarm = 1'b1;
        press(1'b0, 1);
        step(2);
        set_alarm = 1'b0;
        alarm_en = 1'b1;
        run_to(240);
        checks++; if (alarm_ring !== 1'b1 || disp !== 24'h000100) begin fails++; $display("[TB] FAIL snz_ring: got ring %b disp %h expected 1 000100", alarm_ring, disp); end
        snooze = 1'b1;
        step(1);
        snooze = 1'b0;
        run_to(242);
        checks++; if (alarm_ring !== 1'b1) begin fails++; $display("[TB] FAIL snz_latency: got %b expected 1", alarm_ring); end
        run_to(243);
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL snz_enter: got %b expected 0", alarm_ring); end
        run_to(479);
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL snz_hold: got %b expected 0", alarm_ring); end
        run_to(480);
        checks++; if (alarm_ring !== 1'b1) begin fails++; $display("[TB] FAIL snz_rering: got %b expected 1", alarm_ring); end
        snooze = 1'b1; dismiss = 1'b1;
        step(1);
        snooze = 1'b0; dismiss = 1'b0;
        run_to(482);
        checks++; if (alarm_ring !== 1'b1) begin fails++; $display("[TB] FAIL both_latency: got %b expected 1", alarm_ring); end
        run_to(483);
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL both_off: got %b expected 0", alarm_ring); end
        run_to(731);
        checks++; if (alarm_ring !== 1'b0) begin fails++; $display("[TB] FAIL dismiss_wins: got %b expected 0", alarm_ring); end
    endtask

    task automatic test_reset_while_ringing();
        do_reset(1'b1);
        set_alarm = 1'b1;
        press(1'b0, 1);
        step(2);
        set_alarm = 1'b0;
        alarm_en = 1'b1;
        run_to(240);
        checks++; if (alarm_ring !== 1'b1) begin fails++; $display("[TB] FAIL rr_ring: got %b expected 1", alarm_ring); end
        sw = 1'b1;
        step(1);
        checks++; if (disp !== 24'h000000 || pm !== 1'b0) begin fails++; $display("[TB] FAIL rr_disp: got %h pm %b expected 000000 pm 0", disp, pm); end
        checks++; if (alarm_ring !== 1'b0 || tick !== 1'b0) begin fails++; $display("[TB] FAIL rr_ring_tick: got ring %b tick %b expected 0 0", alarm_ring, tick); end
        sw = 1'b0;
        set_alarm = 1'b1; #1;
        checks++; if (disp !== 24'h000000) begin fails++; $display("[TB] FAIL rr_alarm_reg: got %h expected 000000", disp); end
        set_alarm = 1'b0;
        alarm_en = 1'b0;
    endtask

    // Scenario sequence and summary
    initial begin
        $display("[TB] starting digital_clock_alarm bench");
        test_reset();
        test_rollover();
        test_pm12();
        test_auto_repeat();
        test_back_to_back();
        test_adjust_on_tick();
        test_alarm_ring();
        test_snooze();
        test_reset_while_ringing();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
